cordic_seq_ctrl: RTL and testbench

Iteration sequencer for the CORDIC engine. It accepts an operation request with a rotation-mode tag, then drives the iteration index shared by the angle-constant table and the shift/add datapath. It handles the hyperbolic start offset and repeat iterations, and holds the result-valid handshake until the consumer accepts. It sits between the request front-end and the datapath/alpha-table pair.

---
 rtl/cordic_pkg.sv | 27 ++
 rtl/cordic_seq_ctrl_if.sv | 35 +++
 rtl/cordic_iter_next.sv | 41 ++++
 rtl/cordic_seq_ctrl.sv | 108 ++++++++++
 tb/tb_cordic_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// Shared encodings and sizing helpers for the CORDIC iteration sequencer.
package cordic_pkg;

    localparam logic [1:0] MOD_LIN = 2'b00;
    localparam logic [1:0] MOD_CIR = 2'b01;
    localparam logic [1:0] MOD_HYP = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Hyperbolic CORDIC must run these indices twice to converge.
    localparam int REP_IDX_A = 4;
    localparam int REP_IDX_B = 13;

    function automatic int calc_iter(input int frac);
        return frac + 1;
    endfunction

    function automatic int calc_log_iter(input int frac);
        return $clog2(frac + 1);
    endfunction

endpackage

// File: rtl/cordic_seq_ctrl_if.sv
// Request/result handshake plus datapath control bundle for cordic_seq_ctrl.
interface cordic_seq_ctrl_if #(
    parameter int LOG_ITER = 4
);
    import cordic_pkg::*;

    // start_valid/start_ready and out_valid/out_ready are valid/ready pairs:
    // a transfer happens on a clock edge where both are high; valid may not
    // depend on ready, and out_valid holds until it is accepted.
    logic                start_valid;
    logic                start_ready;
    logic [1:0]          mode_i;
    logic [1:0]          mode_o;
    logic                load_o;
    logic                step_o;
    logic [LOG_ITER-1:0] iter_o;
    logic                repeat_o;
    logic                busy_o;
    logic                out_valid;
    logic                out_ready;
    state_e              state_o;

    modport master (
        output start_valid, mode_i, out_ready,
        input  start_ready, mode_o, load_o, step_o, iter_o, repeat_o,
               busy_o, out_valid, state_o
    );

    modport slave (
        input  start_valid, mode_i, out_ready,
        output start_ready, mode_o, load_o, step_o, iter_o, repeat_o,
               busy_o, out_valid, state_o
    );

endinterface

// File: rtl/cordic_iter_next.sv
// Next-index / repeat / last-step rule for one CORDIC micro-rotation.
// Repeat passes exist only when CORDIC_HYP_REPEAT_EN is defined.
module cordic_iter_next
    import cordic_pkg::*;
#(
    parameter int FRAC = 14,
    localparam int ITER = calc_iter(FRAC),
    localparam int LOG_ITER = calc_log_iter(FRAC)
) (
    input  logic [1:0]          mode_i,
    input  logic [LOG_ITER-1:0] iter_i,
    input  logic                repeat_i,
    output logic [LOG_ITER-1:0] iter_o,
    output logic                repeat_o,
    output logic                last_o
);

    logic rep_hit;

`ifdef CORDIC_HYP_REPEAT_EN
    // Repeat indices beyond the table length simply never match.
    always_comb begin
        rep_hit = 1'b0;
        if (mode_i == MOD_HYP && !repeat_i) begin
            if ((int'(iter_i) == REP_IDX_A && REP_IDX_A < ITER) ||
                (int'(iter_i) == REP_IDX_B && REP_IDX_B < ITER)) begin
                rep_hit = 1'b1;
            end
        end
    end
`else
    logic [2:0] unused_rep_inputs;
    assign unused_rep_inputs = {mode_i, repeat_i};
    assign rep_hit = 1'b0;
`endif

    assign iter_o   = rep_hit ? iter_i : iter_i + LOG_ITER'(1);
    assign repeat_o = rep_hit;
    assign last_o   = (int'(iter_i) == ITER - 1) && !rep_hit;

endmodule

// File: rtl/cordic_seq_ctrl.sv
// CORDIC iteration sequencer: accept request, load, step the index, hold result.
// Optional macro CORDIC_HYP_REPEAT_EN inserts hyperbolic repeat passes 4 and 13.
module cordic_seq_ctrl
    import cordic_pkg::*;
#(
    parameter int DEC  = 2,
    parameter int FRAC = 14
) (
    input  logic              clk,
    input  logic              rst,
    cordic_seq_ctrl_if.slave  bus
);

    localparam int ITER     = calc_iter(FRAC);
    localparam int LOG_ITER = calc_log_iter(FRAC);

    if (DEC < 1 || FRAC < 1) begin : g_bad_cfg
        $error("cordic_seq_ctrl: DEC and FRAC must both be at least 1");
    end

    state_e              state_q;
    logic [1:0]          mode_q;
    logic                load_q;
    logic                step_q;
    logic                repeat_q;
    logic                busy_q;
    logic                out_valid_q;
    logic [LOG_ITER-1:0] iter_q;

    logic [LOG_ITER-1:0] iter_d;
    logic                repeat_d;
    logic                last_d;

    cordic_iter_next #(.FRAC(FRAC)) u_iter_next (
        .mode_i   (mode_q),
        .iter_i   (iter_q),
        .repeat_i (repeat_q),
        .iter_o   (iter_d),
        .repeat_o (repeat_d),
        .last_o   (last_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MOD_CIR;
            load_q      <= 1'b0;
            step_q      <= 1'b0;
            repeat_q    <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            iter_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        state_q  <= LOAD;
                        mode_q   <= bus.mode_i;
                        load_q   <= 1'b1;
                        busy_q   <= 1'b1;
                        repeat_q <= 1'b0;
                        // Hyperbolic CORDIC has no index 0 rotation.
                        iter_q   <= (bus.mode_i == MOD_HYP) ? LOG_ITER'(1) : '0;
                    end
                end
                LOAD: begin
                    state_q <= RUN;
                    load_q  <= 1'b0;
                    step_q  <= 1'b1;
                end
                RUN: begin
                    if (last_d) begin
                        state_q     <= DONE;
                        step_q      <= 1'b0;
                        repeat_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        iter_q   <= iter_d;
                        repeat_q <= repeat_d;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.start_ready = (state_q == IDLE) && !rst;
    assign bus.mode_o      = mode_q;
    assign bus.load_o      = load_q;
    assign bus.step_o      = step_q;
    assign bus.iter_o      = iter_q;
    assign bus.busy_o      = busy_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.state_o     = state_q;
`ifdef CORDIC_HYP_REPEAT_EN
    assign bus.repeat_o    = repeat_q;
`else
    assign bus.repeat_o    = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Directed bench for cordic_seq_ctrl with a sequence-list reference model.
module tb_cordic_seq_ctrl;
    import cordic_pkg::*;

`ifdef CORDIC_HYP_REPEAT_EN
    localparam bit REP_EN  = 1'b1;
    localparam int HYP_LAT = 18;
    localparam int HYP_LEN = 16;
`else
    localparam bit REP_EN  = 1'b0;
    localparam int HYP_LAT = 16;
    localparam int HYP_LEN = 14;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_seq_ctrl_if #(.LOG_ITER(4)) bus ();

    cordic_seq_ctrl #(.DEC(2), .FRAC(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int ncmp = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each accepted request expands into the list of {repeat, index} steps
    // the datapath must see; outputs follow that list one entry per cycle.
    logic [4:0] exp_q[$];
    bit         m_busy, m_load, m_step, m_ov, m_rep, chk_en;
    logic [1:0] m_mode = MOD_CIR;
    logic [3:0] m_iter = 4'd0;
    int         m_last_len = 0;

    function automatic void build_seq(input logic [1:0] mode);
        exp_q.delete();
        if (mode == MOD_HYP) begin
            for (int i = 1; i <= 14; i++) begin
                exp_q.push_back({1'b0, 4'(i)});
                if (REP_EN && (i == 4 || i == 13)) exp_q.push_back({1'b1, 4'(i)});
            end
        end else begin
            for (int i = 0; i <= 14; i++) exp_q.push_back({1'b0, 4'(i)});
        end
        m_last_len = exp_q.size();
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_load = 0; m_step = 0; m_ov = 0; m_rep = 0;
            m_mode = MOD_CIR; m_iter = 4'd0;
            exp_q.delete();
        end else if (!m_busy) begin
            if (bus.start_valid) begin
                m_busy = 1; m_load = 1; m_rep = 0;
                m_mode = bus.mode_i;
                build_seq(bus.mode_i);
                m_iter = exp_q[0][3:0];
            end
        end else if (m_load) begin
            m_load = 0; m_step = 1;
            {m_rep, m_iter} = exp_q.pop_front();
        end else if (m_step) begin
            if (exp_q.size() == 0) begin
                m_step = 0; m_ov = 1; m_rep = 0;
            end else begin
                {m_rep, m_iter} = exp_q.pop_front();
            end
        end else if (m_ov && bus.out_ready) begin
            m_ov = 0; m_busy = 0;
        end
        chk_en = 1;
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_outputs",
                  {bus.start_ready, bus.mode_o, bus.load_o, bus.step_o, bus.iter_o,
                   bus.repeat_o, bus.busy_o, bus.out_valid},
                  {(!m_busy && !rst), m_mode, m_load, m_step, m_iter,
                   m_rep, m_busy, m_ov});
        end
    end

    int acc_cnt = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.start_valid && bus.start_ready) acc_cnt++;
            if (bus.out_valid && bus.out_ready) done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    int seq_got[$];
    int lat;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] mode, input logic [1:0] late_mode);
        seq_got.delete();
        bus.mode_i      = mode;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            if (bus.step_o === 1'b1) seq_got.push_back(bus.repeat_o * 100 + int'(bus.iter_o));
            if (lat == 6) bus.mode_i = late_mode;
            tick();
            lat++;
        end
        if (lat >= 40) check("out_valid_seen", 0, 1);
    endtask

    task automatic check_seq(input string name, input int exp_seq[$]);
        int nbad;
        nbad = 0;
        check({name, "_len"}, seq_got.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < seq_got.size(); i++)
            if (seq_got[i] != exp_seq[i]) nbad++;
        check({name, "_elems"}, nbad, 0);
    endtask

    int seq_cir[$] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
`ifdef CORDIC_HYP_REPEAT_EN
    int seq_hyp[$] = '{1, 2, 3, 4, 104, 5, 6, 7, 8, 9, 10, 11, 12, 13, 113, 14};
`else
    int seq_hyp[$] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
`endif

    // ---------------- directed stimulus ----------------
    initial begin
        int a0, d0, k;
        bus.start_valid = 1'b0;
        bus.mode_i      = MOD_CIR;
        bus.out_ready   = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_start_ready", bus.start_ready, 0);
        check("rst_iter", bus.iter_o, 0);
        check("rst_mode", bus.mode_o, 2'b01);
        check("rst_busy_valid", {bus.busy_o, bus.out_valid, bus.load_o, bus.step_o}, 0);
        rst = 1'b0;
        tick();
        check("idle_start_ready", bus.start_ready, 1);

        // Circular
        run_op(MOD_CIR, MOD_CIR);
        check("cir_latency", lat, 17);
        check("cir_model_len", m_last_len, 15);
        check_seq("cir_seq", seq_cir);
        tick();
        check("cir_back_idle", bus.start_ready, 1);

        // Linear
        run_op(MOD_LIN, MOD_LIN);
        check("lin_latency", lat, 17);
        check_seq("lin_seq", seq_cir);
        tick();

        // Hyperbolic, with mode_i changed mid-run
        run_op(MOD_HYP, MOD_CIR);
        check("hyp_latency", lat, HYP_LAT);
        check("hyp_model_len", m_last_len, HYP_LEN);
        check_seq("hyp_seq", seq_hyp);
        check("hyp_mode_held", bus.mode_o, 2'b11);
        tick();

        // Mode 2'b10 runs as circular
        run_op(2'b10, 2'b10);
        check("m10_latency", lat, 17);
        check_seq("m10_seq", seq_cir);
        tick();

        // Backpressure: result held, requests ignored
        bus.out_ready = 1'b0;
        run_op(MOD_CIR, MOD_CIR);
        for (int i = 0; i < 5; i++) begin
            bus.start_valid = 1'b1;
            tick();
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_start_ready", bus.start_ready, 0);
        end
        bus.start_valid = 1'b0;
        bus.out_ready   = 1'b1;
        tick();
        check("bp_released_idle", {bus.start_ready, bus.busy_o, bus.out_valid}, 3'b100);

        // Reset in the middle of a run at index 7
        bus.mode_i = MOD_CIR;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        k = 0;
        while (!(bus.step_o === 1'b1 && bus.iter_o == 4'd7) && k < 30) begin
            tick();
            k++;
        end
        check("rst_mid_reached_7", bus.iter_o, 7);
        rst = 1'b1;
        tick();
        check("rst_mid_outputs",
              {bus.start_ready, bus.mode_o, bus.load_o, bus.step_o, bus.iter_o,
               bus.repeat_o, bus.busy_o, bus.out_valid}, 12'b0_01_0_0_0000_0_0_0);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (20) tick();
        check("rst_mid_no_result", done_cnt - d0, 0);
        run_op(MOD_CIR, MOD_CIR);
        check("after_rst_latency", lat, 17);
        tick();

        // Back-to-back requests with start_valid held high
        a0 = acc_cnt;
        d0 = done_cnt;
        bus.mode_i = MOD_CIR;
        bus.start_valid = 1'b1;
        repeat (60) tick();
        bus.start_valid = 1'b0;
        k = 0;
        while (bus.busy_o !== 1'b0 && k < 40) begin
            tick();
            k++;
        end
        check("b2b_drained", bus.busy_o, 0);
        check("b2b_accepts", acc_cnt - a0, 4);
        check("b2b_one_result_each", done_cnt - d0, acc_cnt - a0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
